// File: rtl/fft_pkg.sv
// fft_pkg: shared types and arithmetic helpers for the FFT 1/N normaliser.
//   cplx_t      complex sample at the default width
//   round_ofs   half-LSB rounding offset for an arithmetic right shift
//   sat         clamp a wide signed value to a signed (w+1)-bit range
//   is_pow2     power-of-two test
//   ilog2       index of the highest set bit
package fft_pkg;

    localparam int unsigned W_DEF        = 15;
    localparam int unsigned BIT_FRAC_DEF = 14;

    typedef struct packed {
        logic signed [W_DEF:0] re;
        logic signed [W_DEF:0] im;
    } cplx_t;

    // Adding this before a >>> sh turns floor into round-half-up.
    function automatic logic [63:0] round_ofs(input int unsigned sh);
        if (sh == 0) begin
            return 64'd0;
        end
        return 64'd1 << (sh - 1);
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                               input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< w) - 64'sd1;
        lo = -(64'sd1 <<< w);
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    function automatic logic is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic int unsigned ilog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (n[i]) begin
                r = unsigned'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cplx_scale_lane.sv
// cplx_scale_lane: two-stage 1/N scaling of one complex sample.
//   S1 registers either x + 2^(p-1) (shift path) or x*inv + 2^(BIT_FRAC-1) (multiply path);
//   S2 registers the arithmetic-shifted result reduced to W+1 bits.
// Macro FFT_SCALE_SAT_EN: when defined the multiply-path result saturates, otherwise it
// wraps. The shift path never overflows and is unaffected.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ld1_i, ld2_i    load enables of S1 and S2 (driven by the top-level handshake)
//   re_i, im_i      input sample
//   inv_i           signed Q(BIT_FRAC) reciprocal for the multiply path
//   pow2_i, p_i     select shift path and its shift amount
//   re_o, im_o      registered scaled sample
module cplx_scale_lane import fft_pkg::*; #(
    parameter int unsigned W        = W_DEF,
    parameter int unsigned BIT_FRAC = BIT_FRAC_DEF,
    parameter int unsigned PBW      = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld1_i,
    input  logic                ld2_i,
    input  logic signed [W:0]   re_i,
    input  logic signed [W:0]   im_i,
    input  logic signed [W:0]   inv_i,
    input  logic                pow2_i,
    input  logic [PBW-1:0]      p_i,
    output logic signed [W:0]   re_o,
    output logic signed [W:0]   im_o
);

    localparam int unsigned PW = 2 * (W + 1);

    logic signed [PW-1:0] re_ext, im_ext, inv_ext, ofs;
    logic signed [PW-1:0] s1_re_d, s1_im_d, s1_re_q, s1_im_q;
    logic                 s1_pow2_q;
    logic [PBW-1:0]       s1_p_q;
    logic signed [63:0]   re_wide, im_wide;
    int unsigned          sh;
    logic signed [W:0]    re_d, im_d, re_q, im_q;

    always_comb begin
        re_ext  = {{(PW - W - 1){re_i[W]}}, re_i};
        im_ext  = {{(PW - W - 1){im_i[W]}}, im_i};
        inv_ext = {{(PW - W - 1){inv_i[W]}}, inv_i};
        ofs     = pow2_i ? PW'(round_ofs(32'(p_i))) : PW'(round_ofs(BIT_FRAC));
        s1_re_d = (pow2_i ? re_ext : re_ext * inv_ext) + ofs;
        s1_im_d = (pow2_i ? im_ext : im_ext * inv_ext) + ofs;
    end

    always_comb begin
        sh      = s1_pow2_q ? 32'(s1_p_q) : BIT_FRAC;
        re_wide = $signed({{(64 - PW){s1_re_q[PW-1]}}, s1_re_q});
        im_wide = $signed({{(64 - PW){s1_im_q[PW-1]}}, s1_im_q});
        if (s1_pow2_q) begin
            re_d = (W + 1)'(re_wide >>> sh);
            im_d = (W + 1)'(im_wide >>> sh);
        end else begin
`ifdef FFT_SCALE_SAT_EN
            re_d = (W + 1)'(sat(re_wide >>> sh, W));
            im_d = (W + 1)'(sat(im_wide >>> sh, W));
`else
            re_d = (W + 1)'(re_wide >>> sh);
            im_d = (W + 1)'(im_wide >>> sh);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_re_q   <= '0;
            s1_im_q   <= '0;
            s1_pow2_q <= 1'b0;
            s1_p_q    <= '0;
            re_q      <= '0;
            im_q      <= '0;
        end else begin
            if (ld1_i) begin
                s1_re_q   <= s1_re_d;
                s1_im_q   <= s1_im_d;
                s1_pow2_q <= pow2_i;
                s1_p_q    <= p_i;
            end
            if (ld2_i) begin
                re_q <= re_d;
                im_q <= im_d;
            end
        end
    end

    assign re_o = re_q;
    assign im_o = im_q;

endmodule

// File: rtl/fft_scale_stream.sv
// fft_scale_stream: streaming 1/N normaliser for FFT/IFFT output frames.
// Power-of-two N uses a rounded arithmetic shift, other N multiply by cfg_inv_n.
// Owns the valid/ready handshake, the frame counter and the per-frame config latch;
// arithmetic lives in cplx_scale_lane (one per lane). Latency 2, throughput 1 beat/cycle.
// Macro FFT_SCALE_SAT_EN (see cplx_scale_lane): saturate instead of wrap on the multiply path.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cfg_n, cfg_inv_n         frame length and its Q(BIT_FRAC) reciprocal, taken on frame start
//   s_valid/s_ready/s_re/s_im/s_last   input stream
//   m_valid/m_ready/m_re/m_im/m_last   output stream
//   frame_err                pulse on acceptance of a beat whose s_last disagrees with N
//   busy                     frame partially accepted or pipeline non-empty
module fft_scale_stream import fft_pkg::*; #(
    parameter int unsigned N_MAX    = 64,
    parameter int unsigned W        = W_DEF,
    parameter int unsigned BIT_FRAC = BIT_FRAC_DEF,
    parameter int unsigned LANES    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [$clog2(N_MAX+1)-1:0]    cfg_n,
    input  logic [W:0]                    cfg_inv_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [LANES*(W+1)-1:0]        s_re,
    input  logic [LANES*(W+1)-1:0]        s_im,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [LANES*(W+1)-1:0]        m_re,
    output logic [LANES*(W+1)-1:0]        m_im,
    output logic                          m_last,
    output logic                          frame_err,
    output logic                          busy
);

    localparam int unsigned NW = $clog2(N_MAX + 1);

    logic          ready_en_q;
    logic          s1_valid_d, s1_valid_q, s1_last_d, s1_last_q;
    logic          s2_valid_d, s2_valid_q, s2_last_d, s2_last_q;
    logic [NW-1:0] cnt_d, cnt_q, n_d, n_q, p_d, p_q;
    logic [W:0]    inv_d, inv_q;
    logic          pow2_d, pow2_q;

    logic          s2_load, s1_adv, accept, first, at_end, beat_last;
    logic [NW-1:0] n_clamp, eff_n, eff_p;
    logic [W:0]    eff_inv;
    logic          eff_pow2;

    always_comb begin
        s2_load = !s2_valid_q || m_ready;
        s1_adv  = s1_valid_q && s2_load;
        // ready_en_q keeps s_ready low until the first edge after reset release.
        s_ready = ready_en_q && (!s1_valid_q || s2_load);
        accept  = s_valid && s_ready;

        if (cfg_n == '0) begin
            n_clamp = NW'(1);
        end else if (cfg_n > NW'(N_MAX)) begin
            n_clamp = NW'(N_MAX);
        end else begin
            n_clamp = cfg_n;
        end

        // The first beat of a frame must already use the new configuration.
        first    = (cnt_q == '0);
        eff_n    = first ? n_clamp : n_q;
        eff_inv  = first ? cfg_inv_n : inv_q;
        eff_pow2 = first ? is_pow2(32'(n_clamp)) : pow2_q;
        eff_p    = first ? NW'(ilog2(32'(n_clamp))) : p_q;

        at_end    = (cnt_q == eff_n - NW'(1));
        beat_last = s_last || at_end;
        frame_err = accept && (s_last != at_end);

        cnt_d  = cnt_q;
        n_d    = n_q;
        inv_d  = inv_q;
        pow2_d = pow2_q;
        p_d    = p_q;
        if (accept) begin
            cnt_d = beat_last ? '0 : cnt_q + NW'(1);
            if (first) begin
                n_d    = n_clamp;
                inv_d  = cfg_inv_n;
                pow2_d = eff_pow2;
                p_d    = eff_p;
            end
        end

        s1_valid_d = s_ready ? accept : s1_valid_q;
        s1_last_d  = accept ? beat_last : s1_last_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        s2_last_d  = s1_adv ? s1_last_q : s2_last_q;

        busy    = (cnt_q != '0) || s1_valid_q || s2_valid_q;
        m_valid = s2_valid_q;
        m_last  = s2_last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            cnt_q      <= '0;
            n_q        <= '0;
            inv_q      <= '0;
            pow2_q     <= 1'b0;
            p_q        <= '0;
        end else begin
            ready_en_q <= 1'b1;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            inv_q      <= inv_d;
            pow2_q     <= pow2_d;
            p_q        <= p_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        cplx_scale_lane #(
            .W        (W),
            .BIT_FRAC (BIT_FRAC),
            .PBW      (NW)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .ld1_i  (accept),
            .ld2_i  (s1_adv),
            .re_i   (s_re[k*(W+1) +: W+1]),
            .im_i   (s_im[k*(W+1) +: W+1]),
            .inv_i  (eff_inv),
            .pow2_i (eff_pow2),
            .p_i    (eff_p),
            .re_o   (m_re[k*(W+1) +: W+1]),
            .im_o   (m_im[k*(W+1) +: W+1])
        );
    end

endmodule

// File: tb/tb_fft_scale_stream.sv
// Directed testbench for fft_scale_stream (default parameters, one lane).
module tb_fft_scale_stream;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [6:0]         cfg_n;
    logic [15:0]        cfg_inv_n;
    logic               s_valid, s_ready, s_last;
    logic [15:0]        s_re, s_im;
    logic               m_valid, m_ready, m_last, frame_err, busy;
    logic [15:0]        m_re, m_im;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] q_re[$];
    logic signed [15:0] q_im[$];
    logic               q_last[$];
    int                 err_idx[$];
    int                 acc_cnt = 0;

    fft_scale_stream u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_n     (cfg_n),
        .cfg_inv_n (cfg_inv_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_re      (s_re),
        .s_im      (s_im),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_re      (m_re),
        .m_im      (m_im),
        .m_last    (m_last),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Inputs change only #1 after posedge, so negedge sees what the next edge will use.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                q_re.push_back(m_re);
                q_im.push_back(m_im);
                q_last.push_back(m_last);
            end
            if (frame_err) err_idx.push_back(acc_cnt);
            if (s_valid && s_ready) acc_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic send_beat(input int re, input int im, input logic last);
        int   n;
        logic rdy;
        s_valid = 1'b1;
        s_re    = 16'(re);
        s_im    = 16'(im);
        s_last  = last;
        n       = 0;
        do begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL send_accept: s_ready=0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        idle();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 50);
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL drain: busy=1 after %0d cycles, required 0", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        m_ready   = 1'b1;
        cfg_n     = 7'd8;
        cfg_inv_n = 16'd0;
        idle();
        s_re = '0;
        s_im = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b, required 0", m_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b, required 0", frame_err); end
        if (m_re !== 16'd0 || m_im !== 16'd0 || m_last !== 1'b0) begin
            errors++; $display("FAIL rst_m_data: got re=%h im=%h last=%b, required 0", m_re, m_im, m_last);
        end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b, required 0", s_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL rel_s_ready_pre: got %b, required 0", s_ready); end
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL rel_s_ready: got %b, required 1", s_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_shift();
        int base, ebase;
        logic signed [15:0] e_re[8];
        logic signed [15:0] e_im[8];
        base  = q_re.size();
        ebase = err_idx.size();
        e_re[0] = 16'sd13;
        e_im[0] = -16'sd12;
        for (int i = 1; i < 8; i++) begin
            e_re[i] = 16'(i);
            e_im[i] = 16'(-i);
        end
        cfg_n     = 7'd8;
        cfg_inv_n = 16'd0;
        send_beat(100, -100, 1'b0);
        idle();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL shift_lat1: m_valid=%b one cycle after accept, required 0", m_valid); end
        @(negedge clk);
        checks += 2;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL shift_lat2: m_valid=%b two cycles after accept, required 1", m_valid); end
        if ($signed(m_re) !== 16'sd13 || $signed(m_im) !== -16'sd12) begin
            errors++; $display("FAIL shift_first: got re=%0d im=%0d, required 13 -12", $signed(m_re), $signed(m_im));
        end
        @(posedge clk);
        #1;
        for (int i = 1; i < 8; i++) send_beat(8 * i + 3, -8 * i, i == 7);
        drain();
        checks++;
        if (q_re.size() != base + 8) begin
            errors++; $display("FAIL shift_count: got %0d beats, required 8", q_re.size() - base);
        end
        for (int i = 0; i < 8; i++) begin
            if (base + i < q_re.size()) begin
                checks++;
                if (q_re[base+i] !== e_re[i] || q_im[base+i] !== e_im[i] || q_last[base+i] !== (i == 7)) begin
                    errors++;
                    $display("FAIL shift_beat%0d: got re=%0d im=%0d last=%b, required re=%0d im=%0d last=%b",
                             i, q_re[base+i], q_im[base+i], q_last[base+i], e_re[i], e_im[i], i == 7);
                end
            end
        end
        checks++;
        if (err_idx.size() != ebase) begin errors++; $display("FAIL shift_err: got %0d pulses, required 0", err_idx.size() - ebase); end
    endtask

    task automatic test_multiply();
        int base, ebase;
        logic signed [15:0] e_re[3];
        logic signed [15:0] e_im[3];
        e_re[0] = 16'sd1000;  e_im[0] = -16'sd1000;
        e_re[1] = 16'sd0;     e_im[1] = 16'sd0;
        e_re[2] = -16'sd9999; e_im[2] = 16'sd9999;
        base  = q_re.size();
        ebase = err_idx.size();
        cfg_n     = 7'd3;
        cfg_inv_n = 16'd5461;
        send_beat(3000, -3000, 1'b0);
        // Mid-frame config change must be ignored.
        cfg_n     = 7'd8;
        cfg_inv_n = 16'd0;
        send_beat(0, 0, 1'b0);
        send_beat(-30000, 30000, 1'b1);
        drain();
        checks++;
        if (q_re.size() != base + 3) begin
            errors++; $display("FAIL mul_count: got %0d beats, required 3", q_re.size() - base);
        end
        for (int i = 0; i < 3; i++) begin
            if (base + i < q_re.size()) begin
                checks++;
                if (q_re[base+i] !== e_re[i] || q_im[base+i] !== e_im[i] || q_last[base+i] !== (i == 2)) begin
                    errors++;
                    $display("FAIL mul_beat%0d: got re=%0d im=%0d last=%b, required re=%0d im=%0d last=%b",
                             i, q_re[base+i], q_im[base+i], q_last[base+i], e_re[i], e_im[i], i == 2);
                end
            end
        end
        checks++;
        if (err_idx.size() != ebase) begin errors++; $display("FAIL mul_err: got %0d pulses, required 0", err_idx.size() - ebase); end
    endtask

    task automatic test_overflow();
        int base;
        logic signed [15:0] e_re;
        logic signed [15:0] e_im;
`ifdef FFT_SCALE_SAT_EN
        e_re = 16'sd32767;
        e_im = -16'sd32768;
`else
        e_re = -16'sd28915;
        e_im = 16'sd28915;
`endif
        base      = q_re.size();
        cfg_n     = 7'd3;
        cfg_inv_n = 16'd20000;
        send_beat(30000, -30000, 1'b0);
        send_beat(0, 0, 1'b0);
        send_beat(0, 0, 1'b1);
        drain();
        checks++;
        if (q_re.size() != base + 3) begin
            errors++; $display("FAIL ovf_count: got %0d beats, required 3", q_re.size() - base);
        end else begin
            checks++;
            if (q_re[base] !== e_re || q_im[base] !== e_im) begin
                errors++; $display("FAIL ovf_value: got re=%0d im=%0d, required re=%0d im=%0d",
                                   q_re[base], q_im[base], e_re, e_im);
            end
        end
    endtask

    task automatic test_clamp();
        int base, ebase;
        base      = q_re.size();
        ebase     = err_idx.size();
        cfg_n     = 7'd0;
        cfg_inv_n = 16'd0;
        send_beat(123, -7, 1'b1);
        send_beat(-32768, 32767, 1'b1);
        cfg_n = 7'd100;
        send_beat(320, -320, 1'b1);
        drain();
        checks++;
        if (q_re.size() != base + 3) begin
            errors++; $display("FAIL clamp_count: got %0d beats, required 3", q_re.size() - base);
        end else begin
            checks += 3;
            if (q_re[base] !== 16'sd123 || q_im[base] !== -16'sd7 || q_last[base] !== 1'b1) begin
                errors++; $display("FAIL clamp_n1_a: got re=%0d im=%0d last=%b, required 123 -7 1",
                                   q_re[base], q_im[base], q_last[base]);
            end
            if (q_re[base+1] !== -16'sd32768 || q_im[base+1] !== 16'sd32767 || q_last[base+1] !== 1'b1) begin
                errors++; $display("FAIL clamp_n1_b: got re=%0d im=%0d last=%b, required -32768 32767 1",
                                   q_re[base+1], q_im[base+1], q_last[base+1]);
            end
            if (q_re[base+2] !== 16'sd5 || q_im[base+2] !== -16'sd5 || q_last[base+2] !== 1'b1) begin
                errors++; $display("FAIL clamp_nmax: got re=%0d im=%0d last=%b, required 5 -5 1",
                                   q_re[base+2], q_im[base+2], q_last[base+2]);
            end
        end
        checks++;
        if (err_idx.size() != ebase + 1) begin
            errors++; $display("FAIL clamp_err: got %0d pulses, required 1", err_idx.size() - ebase);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base      = q_re.size();
        cfg_n     = 7'd4;
        cfg_inv_n = 16'd0;
        m_ready   = 1'b0;
        send_beat(16, -16, 1'b0);
        send_beat(32, -32, 1'b0);
        s_re = 16'd48;
        s_im = -16'sd48;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0 || m_valid !== 1'b1 || $signed(m_re) !== 16'sd4 ||
                $signed(m_im) !== -16'sd4 || m_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: got s_ready=%b m_valid=%b re=%0d im=%0d last=%b, required 0 1 4 -4 0",
                         c, s_ready, m_valid, $signed(m_re), $signed(m_im), m_last);
            end
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send_beat(48, -48, 1'b0);
        send_beat(64, -64, 1'b1);
        drain();
        checks++;
        if (q_re.size() != base + 4) begin
            errors++; $display("FAIL bp_count: got %0d beats, required 4", q_re.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            if (base + i < q_re.size()) begin
                checks++;
                if (q_re[base+i] !== 16'(4 * (i + 1)) || q_im[base+i] !== 16'(-4 * (i + 1)) ||
                    q_last[base+i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL bp_beat%0d: got re=%0d im=%0d last=%b, required re=%0d im=%0d last=%b",
                             i, q_re[base+i], q_im[base+i], q_last[base+i], 4 * (i + 1), -4 * (i + 1), i == 3);
                end
            end
        end
    endtask

    task automatic test_framing();
        int base, ebase, abase, j;
        base      = q_re.size();
        ebase     = err_idx.size();
        abase     = acc_cnt;
        cfg_n     = 7'd4;
        cfg_inv_n = 16'd0;
        j = 0;
        for (int i = 0; i < 3; i++) begin send_beat(4 * j, -4 * j, i == 2); j++; end
        for (int i = 0; i < 4; i++) begin send_beat(4 * j, -4 * j, i == 3); j++; end
        for (int i = 0; i < 4; i++) begin send_beat(4 * j, -4 * j, 1'b0); j++; end
        drain();
        checks++;
        if (q_re.size() != base + 11) begin
            errors++; $display("FAIL frm_count: got %0d beats, required 11", q_re.size() - base);
        end
        for (int i = 0; i < 11; i++) begin
            if (base + i < q_re.size()) begin
                checks++;
                if (q_re[base+i] !== 16'(i) || q_im[base+i] !== 16'(-i) ||
                    q_last[base+i] !== (i == 2 || i == 6 || i == 10)) begin
                    errors++;
                    $display("FAIL frm_beat%0d: got re=%0d im=%0d last=%b, required re=%0d im=%0d last=%b",
                             i, q_re[base+i], q_im[base+i], q_last[base+i], i, -i, i == 2 || i == 6 || i == 10);
                end
            end
        end
        checks++;
        if (err_idx.size() != ebase + 2) begin
            errors++; $display("FAIL frm_err_count: got %0d pulses, required 2", err_idx.size() - ebase);
        end else begin
            checks++;
            if (err_idx[ebase] - abase != 2 || err_idx[ebase+1] - abase != 10) begin
                errors++; $display("FAIL frm_err_pos: got beats %0d,%0d, required 2,10",
                                   err_idx[ebase] - abase, err_idx[ebase+1] - abase);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int base, ebase;
        cfg_n     = 7'd4;
        cfg_inv_n = 16'd0;
        base      = q_re.size();
        send_beat(400, -400, 1'b0);
        send_beat(800, -800, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_m_valid: got %b, required 0", m_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_s_ready: got %b, required 0", s_ready); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (q_re.size() != base) begin
            errors++; $display("FAIL mid_rst_partial: got %0d beats out, required 0", q_re.size() - base);
        end
        ebase = err_idx.size();
        for (int i = 0; i < 4; i++) send_beat(4 * i, -4 * i, i == 3);
        drain();
        checks++;
        if (q_re.size() != base + 4) begin
            errors++; $display("FAIL mid_rst_count: got %0d beats, required 4", q_re.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            if (base + i < q_re.size()) begin
                checks++;
                if (q_re[base+i] !== 16'(i) || q_im[base+i] !== 16'(-i) || q_last[base+i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL mid_rst_beat%0d: got re=%0d im=%0d last=%b, required re=%0d im=%0d last=%b",
                             i, q_re[base+i], q_im[base+i], q_last[base+i], i, -i, i == 3);
                end
            end
        end
        checks++;
        if (err_idx.size() != ebase) begin
            errors++; $display("FAIL mid_rst_err: got %0d pulses, required 0", err_idx.size() - ebase);
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_multiply();
        test_overflow();
        test_clamp();
        test_back_to_back();
        test_framing();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
